// File: rtl/ren_wb_pkg.sv
// ren_wb_pkg: shared state encoding and bus geometry for the convolver Wishbone master
// Provides: wb_state_e, WB_BYTE_STRIDE, WB_DATA_W, WB_ADR_W, WB_SEL_W
package ren_wb_pkg;
    localparam int WB_BYTE_STRIDE = 4;
    localparam int WB_DATA_W      = 32;
    localparam int WB_ADR_W       = 32;
    localparam int WB_SEL_W       = 4;
    typedef enum logic [2:0] {IDLE, WDAT, BUS, RSP, FIN} wb_state_e;
endpackage

// File: rtl/ren_wb_tmo_cnt.sv
// ren_wb_tmo_cnt: clearable watchdog counter flagging the TIMEOUT_CYCLES-th enabled cycle
// Ports: clk_i clock, rst_i async active-high reset, clr_i restart count,
//        en_i count this cycle, expire_o this enabled cycle reaches TIMEOUT_CYCLES
module ren_wb_tmo_cnt #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TMO_WIDTH      = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    logic [TMO_WIDTH-1:0] cnt_q, cnt_d;
    assign cnt_d    = clr_i ? '0 : en_i ? cnt_q + TMO_WIDTH'(1) : cnt_q;
    assign expire_o = en_i && (cnt_q == TMO_WIDTH'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) cnt_q <= '0;
        else cnt_q <= cnt_d;
endmodule

// File: rtl/ren_conv_wb_master.sv
// ren_conv_wb_master: Wishbone classic burst initiator for the convolver array slave bus
// Ports: cmd_* command handshake (we/adr/len/sel), wdat_* write beat stream in,
//        rdat_* read beat stream out, done/err/busy status, wbm_* Wishbone master bus
module ren_conv_wb_master
    import ren_wb_pkg::*;
#(
    parameter int LEN_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TMO_WIDTH      = 8
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_we,
    input  logic [WB_ADR_W-1:0]  cmd_adr,
    input  logic [LEN_WIDTH-1:0] cmd_len,
    input  logic [WB_SEL_W-1:0]  cmd_sel,
    input  logic                 wdat_valid,
    output logic                 wdat_ready,
    input  logic [WB_DATA_W-1:0] wdat_data,
    output logic                 rdat_valid,
    input  logic                 rdat_ready,
    output logic [WB_DATA_W-1:0] rdat_data,
    output logic                 done,
    output logic                 err,
    output logic                 busy,
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    output logic                 wbm_we_o,
    output logic [WB_SEL_W-1:0]  wbm_sel_o,
    output logic [WB_ADR_W-1:0]  wbm_adr_o,
    output logic [WB_DATA_W-1:0] wbm_dat_o,
    input  logic                 wbm_ack_i,
    input  logic [WB_DATA_W-1:0] wbm_dat_i
);
    wb_state_e            state_q;
    logic [LEN_WIDTH-1:0] beats_q;
    logic                 tmo_expire;

    // Counter is held clear outside BUS so every beat starts its own watchdog window
    ren_wb_tmo_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TMO_WIDTH(TMO_WIDTH)) u_tmo (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .clr_i   (state_q != BUS),
        .en_i    (state_q == BUS && !wbm_ack_i),
        .expire_o(tmo_expire)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i)
        if (wb_rst_i) begin
            state_q    <= IDLE;
            beats_q    <= '0;
            cmd_ready  <= 1'b0;
            wdat_ready <= 1'b0;
            rdat_valid <= 1'b0;
            rdat_data  <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
            wbm_cyc_o  <= 1'b0;
            wbm_stb_o  <= 1'b0;
            wbm_we_o   <= 1'b0;
            wbm_sel_o  <= '0;
            wbm_adr_o  <= '0;
            wbm_dat_o  <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state_q)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready  <= 1'b0;
                        busy       <= 1'b1;
                        wbm_we_o   <= cmd_we;
                        wbm_adr_o  <= cmd_adr;
                        wbm_sel_o  <= cmd_sel;
                        beats_q    <= cmd_len;
                        wdat_ready <= cmd_we;
                        wbm_cyc_o  <= !cmd_we;
                        wbm_stb_o  <= !cmd_we;
                        state_q    <= cmd_we ? WDAT : BUS;
                    end
                end
                WDAT: if (wdat_valid) begin
                    wbm_dat_o  <= wdat_data;
                    wdat_ready <= 1'b0;
                    wbm_cyc_o  <= 1'b1;
                    wbm_stb_o  <= 1'b1;
                    state_q    <= BUS;
                end
                BUS: begin
                    // Ack takes priority over a watchdog expiring in the same cycle
                    if (wbm_ack_i) begin
                        wbm_stb_o <= 1'b0;
                        if (!wbm_we_o) begin
                            rdat_data  <= wbm_dat_i;
                            rdat_valid <= 1'b1;
                            state_q    <= RSP;
                        end else if (beats_q == '0) begin
                            wbm_cyc_o <= 1'b0;
                            done      <= 1'b1;
                            state_q   <= FIN;
                        end else begin
                            wbm_adr_o  <= wbm_adr_o + WB_ADR_W'(WB_BYTE_STRIDE);
                            beats_q    <= beats_q - LEN_WIDTH'(1);
                            wdat_ready <= 1'b1;
                            state_q    <= WDAT;
                        end
                    end else if (tmo_expire) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        done      <= 1'b1;
                        err       <= 1'b1;
                        state_q   <= FIN;
                    end
                end
                RSP: if (rdat_ready) begin
                    rdat_valid <= 1'b0;
                    if (beats_q == '0) begin
                        wbm_cyc_o <= 1'b0;
                        done      <= 1'b1;
                        state_q   <= FIN;
                    end else begin
                        wbm_adr_o <= wbm_adr_o + WB_ADR_W'(WB_BYTE_STRIDE);
                        beats_q   <= beats_q - LEN_WIDTH'(1);
                        wbm_stb_o <= 1'b1;
                        state_q   <= BUS;
                    end
                end
                FIN: begin
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_ren_conv_wb_master.sv
// tb_ren_conv_wb_master: randomized self-checking bench for the convolver Wishbone master
module tb_ren_conv_wb_master;
    localparam int TMO = 8;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b0;
    logic        cmd_valid = 1'b0, cmd_we = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_adr = '0;
    logic [7:0]  cmd_len = '0;
    logic [3:0]  cmd_sel = '0;
    logic        wdat_valid = 1'b0;
    logic        wdat_ready;
    logic [31:0] wdat_data = '0;
    logic        rdat_valid;
    logic        rdat_ready = 1'b0;
    logic [31:0] rdat_data;
    logic        done, err, busy;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;

    int errors = 0, checks = 0;

    ren_conv_wb_master #(.LEN_WIDTH(8), .TIMEOUT_CYCLES(TMO), .TMO_WIDTH(8)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_adr(cmd_adr),
        .cmd_len(cmd_len), .cmd_sel(cmd_sel),
        .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat_data(wdat_data),
        .rdat_valid(rdat_valid), .rdat_ready(rdat_ready), .rdat_data(rdat_data),
        .done(done), .err(err), .busy(busy),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Slave: acks `ack_lat` cycles after stb is first seen (1 = registered ack), never when 0
    logic [31:0] rd_tab [16];
    int ack_lat = 1;
    int sc = 0;
    always @(posedge wb_clk_i or posedge wb_rst_i)
        if (wb_rst_i) begin
            wbm_ack_i <= 1'b0;
            wbm_dat_i <= '0;
            sc <= 0;
        end else begin
            wbm_ack_i <= 1'b0;
            if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i) begin
                if (ack_lat > 0 && sc + 1 >= ack_lat) begin
                    wbm_ack_i <= 1'b1;
                    wbm_dat_i <= rd_tab[wbm_adr_o[5:2]];
                    sc <= 0;
                end else sc <= sc + 1;
            end else sc <= 0;
        end

    typedef struct packed {logic [31:0] adr; logic we; logic [3:0] sel; logic [31:0] dat;} beat_t;
    beat_t mon[$];
    int cyc_n = 0, stb_hi = 0, stb_rise = 0, cyc_rise = 0, done_n = 0, err_n = 0;
    logic stb_prev = 1'b0, cyc_prev = 1'b0;
    always @(posedge wb_clk_i) begin
        cyc_n <= cyc_n + 1;
        stb_prev <= wbm_stb_o;
        cyc_prev <= wbm_cyc_o;
        if (wbm_stb_o) stb_hi <= stb_hi + 1;
        if (wbm_stb_o && !stb_prev) stb_rise <= stb_rise + 1;
        if (wbm_cyc_o && !cyc_prev) cyc_rise <= cyc_rise + 1;
        if (done) done_n <= done_n + 1;
        if (done && err) err_n <= err_n + 1;
        if (wbm_cyc_o && wbm_stb_o && wbm_ack_i)
            mon.push_back({wbm_adr_o, wbm_we_o, wbm_sel_o, wbm_we_o ? wbm_dat_o : wbm_dat_i});
    end

    // One command end to end; the expected bus trace is built from the burst rules directly
    task automatic run_cmd(input string nm, input bit we, input logic [31:0] adr, input int len,
                           input logic [3:0] sel, input int lat, input logic [31:0] w0,
                           input bit eager, input int stall_beat, input int rst_beat);
        logic [31:0] wd[$];
        logic [31:0] held = '0, a;
        int wi = 0, ri = 0, stall = 0, t0 = 0, td = 0, mb, sh0, sr0, cr0, dn0, en0, n_ok, nb;
        bit tmo, was_stalled = 1'b0, seen_done = 1'b0, got_err = 1'b0;
        beat_t b;
        tmo  = (lat == 0 || lat >= TMO);
        nb   = len + 1;
        n_ok = tmo ? 0 : nb;
        ack_lat = lat;
        for (int i = 0; i < nb; i++) wd.push_back(i == 0 ? w0 : $urandom);
        @(negedge wb_clk_i);
        mb = mon.size(); sh0 = stb_hi; sr0 = stb_rise; cr0 = cyc_rise; dn0 = done_n; en0 = err_n;
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_len = 8'(len); cmd_sel = sel;
        for (int k = 0; k < 20 && cmd_ready !== 1'b1; k++) @(negedge wb_clk_i);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s accept: cmd_ready=%b expected 1", nm, cmd_ready);
            cmd_valid = 1'b0;
            return;
        end
        @(negedge wb_clk_i);
        t0 = cyc_n;
        cmd_valid = 1'b0; cmd_we = 1'($urandom); cmd_adr = $urandom; cmd_len = 8'($urandom);
        for (int k = 0; k < 500 && !seen_done; k++) begin
            if (k == 0) begin
                checks++;
                if ({busy, cmd_ready} !== 2'b10) begin
                    errors++;
                    $display("FAIL %s busy_ready: got=%b expected 10", nm, {busy, cmd_ready});
                end
            end
            if (rst_beat >= 0 && mon.size() - mb == rst_beat && wbm_stb_o) begin
                #2 wb_rst_i = 1'b1;
                #1 checks++;
                if ({wbm_cyc_o, wbm_stb_o, rdat_valid, done, busy, cmd_ready} !== 6'b0) begin
                    errors++;
                    $display("FAIL %s reset_release: cyc/stb/rvld/done/busy/rdy=%b expected 000000", nm,
                             {wbm_cyc_o, wbm_stb_o, rdat_valid, done, busy, cmd_ready});
                end
                @(negedge wb_clk_i);
                wb_rst_i = 1'b0; wdat_valid = 1'b0; rdat_ready = 1'b0;
                repeat (2) @(negedge wb_clk_i);
                checks++;
                if ({cmd_ready, busy, done} !== 3'b100) begin
                    errors++;
                    $display("FAIL %s after_reset: rdy/busy/done=%b expected 100", nm, {cmd_ready, busy, done});
                end
                return;
            end
            if (done) begin
                seen_done = 1'b1;
                td = cyc_n;
                got_err = err;
            end
            wdat_valid = (wi < nb) && (eager || $urandom_range(0, 1) == 1);
            wdat_data  = wdat_valid ? wd[wi] : $urandom;
            if (wdat_valid && wdat_ready) wi++;
            rdat_ready = 1'b0;
            if (rdat_valid) begin
                if (was_stalled) begin
                    checks++;
                    if (rdat_data !== held) begin
                        errors++;
                        $display("FAIL %s rdat_stable: got=%h expected %h", nm, rdat_data, held);
                    end
                end
                held = rdat_data;
                if (ri == stall_beat && stall < 3) stall++;
                else rdat_ready = eager || $urandom_range(0, 1) == 1;
                was_stalled = !rdat_ready;
                if (rdat_ready) begin
                    a = adr + 32'(4 * ri);
                    checks++;
                    if (rdat_data !== rd_tab[a[5:2]]) begin
                        errors++;
                        $display("FAIL %s rdat[%0d]: got=%h expected %h", nm, ri, rdat_data, rd_tab[a[5:2]]);
                    end
                    ri++;
                end
            end else was_stalled = 1'b0;
            if (!seen_done) @(negedge wb_clk_i);
        end
        wdat_valid = 1'b0;
        rdat_ready = 1'b0;
        checks++;
        if (seen_done !== 1'b1) begin
            errors++;
            $display("FAIL %s done_seen: got=%b expected 1 within cycle budget", nm, seen_done);
        end
        checks++;
        if (got_err !== tmo) begin
            errors++;
            $display("FAIL %s err: got=%b expected %b", nm, got_err, tmo);
        end
        if (we && len == 0 && lat == 1 && eager) begin
            checks++;
            if (td - t0 !== 3) begin
                errors++;
                $display("FAIL %s latency: done %0d cycles after accept, expected 3", nm, td - t0);
            end
        end
        @(negedge wb_clk_i);
        checks++;
        if ({done, err, busy, cmd_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL %s idle_after: done/err/busy/rdy=%b expected 0001", nm, {done, err, busy, cmd_ready});
        end
        checks++;
        if (done_n - dn0 !== 1 || err_n - en0 !== int'(tmo)) begin
            errors++;
            $display("FAIL %s done_count: done=%0d err=%0d expected 1 and %0d", nm, done_n - dn0, err_n - en0, int'(tmo));
        end
        checks++;
        if (cyc_rise - cr0 !== 1) begin
            errors++;
            $display("FAIL %s cyc_rise: got=%0d expected 1", nm, cyc_rise - cr0);
        end
        checks++;
        if (stb_rise - sr0 !== (tmo ? 1 : nb)) begin
            errors++;
            $display("FAIL %s stb_rise: got=%0d expected %0d", nm, stb_rise - sr0, tmo ? 1 : nb);
        end
        checks++;
        if (stb_hi - sh0 !== (tmo ? TMO : nb * (lat + 1))) begin
            errors++;
            $display("FAIL %s stb_cycles: got=%0d expected %0d", nm, stb_hi - sh0, tmo ? TMO : nb * (lat + 1));
        end
        checks++;
        if (wi !== (we ? (tmo ? 1 : nb) : 0)) begin
            errors++;
            $display("FAIL %s wdat_taken: got=%0d expected %0d", nm, wi, we ? (tmo ? 1 : nb) : 0);
        end
        checks++;
        if (ri !== (we ? 0 : n_ok)) begin
            errors++;
            $display("FAIL %s rdat_count: got=%0d expected %0d", nm, ri, we ? 0 : n_ok);
        end
        checks++;
        if (mon.size() - mb !== n_ok) begin
            errors++;
            $display("FAIL %s beats: got=%0d expected %0d", nm, mon.size() - mb, n_ok);
        end
        for (int i = 0; i < n_ok && mb + i < mon.size(); i++) begin
            a = adr + 32'(4 * i);
            b = mon[mb + i];
            checks++;
            if (b !== {a, we, sel, we ? wd[i] : rd_tab[a[5:2]]}) begin
                errors++;
                $display("FAIL %s beat%0d: adr=%h we=%b sel=%h dat=%h expected adr=%h we=%b sel=%h dat=%h",
                         nm, i, b.adr, b.we, b.sel, b.dat, a, we, sel, we ? wd[i] : rd_tab[a[5:2]]);
            end
        end
    endtask

    task automatic fill_tab();
        for (int j = 0; j < 16; j++) rd_tab[j] = $urandom;
    endtask

    task automatic test_reset();
        #1 wb_rst_i = 1'b1;
        #1 checks++;
        if ({cmd_ready, wdat_ready, rdat_valid, done, err, busy, wbm_cyc_o, wbm_stb_o, wbm_we_o} !== 9'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got=%b expected 000000000",
                     {cmd_ready, wdat_ready, rdat_valid, done, err, busy, wbm_cyc_o, wbm_stb_o, wbm_we_o});
        end
        checks++;
        if ({wbm_sel_o, wbm_adr_o, wbm_dat_o, rdat_data} !== 100'b0) begin
            errors++;
            $display("FAIL reset_data: sel=%h adr=%h dat=%h rdat=%h expected all 0", wbm_sel_o, wbm_adr_o, wbm_dat_o, rdat_data);
        end
        repeat (2) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        repeat (2) @(negedge wb_clk_i);
        checks++;
        if ({cmd_ready, busy} !== 2'b10) begin
            errors++;
            $display("FAIL reset_idle: rdy/busy=%b expected 10", {cmd_ready, busy});
        end
    endtask

    task automatic test_single_write();
        fill_tab();
        run_cmd("single_write", 1'b1, 32'h3000_0010, 0, 4'hF, 1, 32'hDEAD_BEEF, 1'b1, -1, -1);
    endtask

    task automatic test_read_burst();
        fill_tab();
        rd_tab[0] = 32'h11; rd_tab[1] = 32'h22; rd_tab[2] = 32'h33; rd_tab[3] = 32'h44;
        run_cmd("read_burst", 1'b0, 32'h3000_0100, 3, 4'hF, 1, 32'h0, 1'b1, 1, -1);
    endtask

    task automatic test_timeout();
        run_cmd("timeout_noack", 1'b1, 32'h3000_0200, 2, 4'h3, 0, $urandom, 1'b1, -1, -1);
        run_cmd("timeout_late_ack", 1'b0, 32'h3000_0300, 1, 4'hC, TMO, 32'h0, 1'b1, -1, -1);
        run_cmd("ack_at_expiry", 1'b1, 32'h3000_0400, 0, 4'hF, TMO - 1, $urandom, 1'b1, -1, -1);
    endtask

    task automatic test_wrap();
        run_cmd("addr_wrap", 1'b1, 32'hFFFF_FFFC, 1, 4'h5, 1, $urandom, 1'b0, -1, -1);
    endtask

    task automatic test_reset_mid_burst();
        run_cmd("reset_mid", 1'b1, 32'h3000_0500, 3, 4'hF, 1, $urandom, 1'b1, -1, 1);
        fill_tab();
        run_cmd("post_reset", 1'b0, 32'h3000_0600, 2, 4'hA, 2, 32'h0, 1'b0, 0, -1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            fill_tab();
            run_cmd("random", 1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 5)), 4'($urandom),
                    int'($urandom_range(1, 3)), $urandom, 1'b0, int'($urandom_range(0, 2)), -1);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        fill_tab();
        test_reset();
        test_single_write();
        test_read_burst();
        test_timeout();
        test_wrap();
        test_reset_mid_burst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
